// File: rtl/vec_pkg.sv
// Shared types and helpers for the vector multiply-accumulate lane.
package vec_pkg;

    typedef logic signed [7:0]  int8_t;
    typedef logic signed [31:0] acc_t;

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        FLUSH,
        HOLD
    } state_t;

    // Number of FIFO pops that make up one activation vector.
    function automatic int nchunks(input int vec_elements, input int bytes_per_read);
        return vec_elements / bytes_per_read;
    endfunction

endpackage

// File: rtl/vec_mac_stage_chunk_dot.sv
// Registered elementwise int8 multiply and adder tree over one FIFO chunk.
module chunk_dot
    import vec_pkg::*;
#(
    parameter int BytesPerRead = 4,
    parameter int PsumW        = 16 + $clog2(BytesPerRead)
) (
    input  logic                          clk_in,
    input  logic                          rst_in,
    input  logic                          pop,
    input  logic [BytesPerRead-1:0][7:0]  data,
    input  logic [BytesPerRead-1:0][7:0]  weights,
    output logic signed [PsumW-1:0]       psum,
    output logic                          psum_v
);

    logic signed [PsumW-1:0] sum;
    logic signed [15:0]      prod;

    // Sign-extend each byte pair to 16 bits, multiply, and sum into the widened partial sum.
    always_comb begin
        sum  = '0;
        prod = '0;
        for (int j = 0; j < BytesPerRead; j++) begin
            prod = 16'(int8_t'(data[j])) * 16'(int8_t'(weights[j]));
            sum  = sum + PsumW'(prod);
        end
    end

    // Capture the partial sum on a pop; psum_v marks the cycle in which it is fresh.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            psum   <= '0;
            psum_v <= 1'b0;
        end else begin
            psum_v <= pop;
            if (pop) begin
                psum <= sum;
            end
        end
    end

endmodule

// File: rtl/vec_mac_stage.sv
// One neuron lane: pops an int8 vector from the FIFO, dots it with local weights, adds bias, optional ReLU.
module vec_mac_stage
    import vec_pkg::*;
#(
    parameter int VecElements  = 8,
    parameter int BytesPerRead = 4,
    parameter int Relu         = 1
) (
    input  logic                               clk_in,
    input  logic                               rst_in,
    input  logic                               in_avail,
    output logic                               rd_en,
    input  logic [BytesPerRead-1:0][7:0]       rd_data,
    input  logic                               wt_wr_en,
    input  logic [$clog2(VecElements)-1:0]     wt_addr,
    input  logic [7:0]                         wt_data,
    input  logic                               bias_wr_en,
    input  logic [31:0]                        bias_data,
    output logic                               out_valid,
    input  logic                               out_ready,
    output logic [31:0]                        out_data
);

    localparam int NChunk = nchunks(VecElements, BytesPerRead);
    localparam int ChunkW = (NChunk > 1) ? $clog2(NChunk) : 1;
    localparam int AddrW  = $clog2(VecElements);
    localparam int PsumW  = 16 + $clog2(BytesPerRead);

    state_t                          state;
    state_t                          next_state;
    logic [ChunkW-1:0]               chunk_idx;
    logic                            last_issued;
    acc_t                            acc;
    acc_t                            bias;
    acc_t                            result;
    acc_t                            activated;
    logic [VecElements-1:0][7:0]     weights;
    logic [BytesPerRead-1:0][7:0]    chunk_wt;
    logic signed [PsumW-1:0]         psum;
    logic                            psum_v;

    assign rd_en = in_avail && (state == IDLE || state == ACCUM) && !last_issued;

    // Pick the slice of weights that lines up with the chunk currently on rd_data.
    always_comb begin
        chunk_wt = '0;
        for (int j = 0; j < BytesPerRead; j++) begin
            chunk_wt[j] = weights[AddrW'(int'(chunk_idx) * BytesPerRead + j)];
        end
    end

    chunk_dot #(
        .BytesPerRead (BytesPerRead),
        .PsumW        (PsumW)
    ) u_chunk_dot (
        .clk_in  (clk_in),
        .rst_in  (rst_in),
        .pop     (rd_en),
        .data    (rd_data),
        .weights (chunk_wt),
        .psum    (psum),
        .psum_v  (psum_v)
    );

    // Final bias add (wrapping) and optional clamp of negative results.
    always_comb begin
        result    = acc + bias;
        activated = result;
        if (Relu != 0 && result < 0) begin
            activated = '0;
        end
    end

    // Next-state logic: leave ACCUM only once the last chunk's psum is being folded into acc.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (rd_en) next_state = ACCUM;
            ACCUM:   if (last_issued && psum_v) next_state = FLUSH;
            FLUSH:   next_state = HOLD;
            HOLD:    if (out_valid && out_ready) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Chunk bookkeeping, accumulation and the output register; the handshake clears the vector.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            chunk_idx   <= '0;
            last_issued <= 1'b0;
            acc         <= '0;
            out_valid   <= 1'b0;
            out_data    <= '0;
        end else begin
            if (rd_en) begin
                chunk_idx <= chunk_idx + ChunkW'(1);
                if (chunk_idx == ChunkW'(NChunk - 1)) begin
                    last_issued <= 1'b1;
                end
            end
            if (state == FLUSH) begin
                out_data  <= activated;
                out_valid <= 1'b1;
            end
            if (state == HOLD && out_valid && out_ready) begin
                out_valid   <= 1'b0;
                acc         <= '0;
                chunk_idx   <= '0;
                last_issued <= 1'b0;
            end else if (psum_v) begin
                acc <= acc + acc_t'(psum);
            end
        end
    end

    // Weight and bias storage; writes land on the edge, so a same-cycle pop sees the old value.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            weights <= '0;
            bias    <= '0;
        end else begin
            if (wt_wr_en) begin
                weights[wt_addr] <= wt_data;
            end
            if (bias_wr_en) begin
                bias <= bias_data;
            end
        end
    end

endmodule

// File: tb/tb_vec_mac_stage.sv
// Scoreboard bench for vec_mac_stage: a ReLU lane and a pass-through lane share one stimulus stream.
module tb_vec_mac_stage;

    localparam int VE  = 8;
    localparam int BPR = 4;
    localparam int NCH = VE / BPR;

    logic                  clk_in = 1'b0;
    logic                  rst_in;
    logic                  in_avail;
    logic [BPR-1:0][7:0]   rd_data;
    logic                  wt_wr_en;
    logic [2:0]            wt_addr;
    logic [7:0]            wt_data;
    logic                  bias_wr_en;
    logic [31:0]           bias_data;
    logic                  out_ready;
    logic                  rd_en_r, rd_en_n;
    logic                  out_valid_r, out_valid_n;
    logic [31:0]           out_data_r, out_data_n;

    logic [BPR-1:0][7:0]   fifo [$];
    int                    exp_r [$];
    int                    exp_n [$];
    int                    mw [VE];
    int                    mb;
    bit                    gate;
    int                    n_checks;
    int                    n_pass;
    int                    cycle;
    int                    pop_count;
    int                    pops_vec;
    int                    last_pop;
    bit                    prev_valid;
    logic [31:0]           prev_data_r, prev_data_n;

    // Free-running clock.
    always #5 clk_in = ~clk_in;

    vec_mac_stage #(.VecElements(VE), .BytesPerRead(BPR), .Relu(1)) dut_r (
        .clk_in(clk_in), .rst_in(rst_in), .in_avail(in_avail), .rd_en(rd_en_r), .rd_data(rd_data),
        .wt_wr_en(wt_wr_en), .wt_addr(wt_addr), .wt_data(wt_data),
        .bias_wr_en(bias_wr_en), .bias_data(bias_data),
        .out_valid(out_valid_r), .out_ready(out_ready), .out_data(out_data_r)
    );

    vec_mac_stage #(.VecElements(VE), .BytesPerRead(BPR), .Relu(0)) dut_n (
        .clk_in(clk_in), .rst_in(rst_in), .in_avail(in_avail), .rd_en(rd_en_n), .rd_data(rd_data),
        .wt_wr_en(wt_wr_en), .wt_addr(wt_addr), .wt_data(wt_data),
        .bias_wr_en(bias_wr_en), .bias_data(bias_data),
        .out_valid(out_valid_n), .out_ready(out_ready), .out_data(out_data_n)
    );

    // Single comparison point: every check in the bench goes through here.
    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    endtask

    // Reference dot product: plain integer sum of products plus bias, 32-bit wrap, optional clamp.
    function automatic int model(input logic [7:0] v [VE], input bit relu);
        int s;
        s = mb;
        for (int i = 0; i < VE; i++) s += int'($signed(v[i])) * mw[i];
        if (relu && s < 0) s = 0;
        return s;
    endfunction

    // Queue one vector into the FIFO model and log the expected results for both lanes.
    task automatic applyStimulus(input logic [7:0] v [VE]);
        logic [BPR-1:0][7:0] chunk;
        exp_r.push_back(model(v, 1'b1));
        exp_n.push_back(model(v, 1'b0));
        for (int c = 0; c < NCH; c++) begin
            for (int j = 0; j < BPR; j++) chunk[j] = v[c*BPR + j];
            fifo.push_back(chunk);
        end
    endtask

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic write_weights(input int w [VE]);
        for (int i = 0; i < VE; i++) begin
            wt_wr_en = 1'b1;
            wt_addr  = 3'(i);
            wt_data  = 8'(w[i]);
            tick();
        end
        wt_wr_en = 1'b0;
        mw = w;
    endtask

    task automatic write_bias(input int b);
        bias_wr_en = 1'b1;
        bias_data  = b;
        tick();
        bias_wr_en = 1'b0;
        mb = b;
    endtask

    task automatic wait_drain(input int budget);
        int n = 0;
        while (exp_r.size() > 0 && n < budget) begin
            tick();
            n++;
        end
        if (exp_r.size() > 0) begin
            checkOutput("drain_timeout", exp_r.size(), 0);
            exp_r.delete();
            exp_n.delete();
            fifo.delete();
        end
    endtask

    task automatic wait_valid(input int budget);
        int n = 0;
        while (!out_valid_r && n < budget) begin
            tick();
            n++;
        end
        if (!out_valid_r) checkOutput("valid_timeout", 32'(out_valid_r), 1);
    endtask

    task automatic wait_pop(input int budget);
        int start = pop_count;
        int n = 0;
        while (pop_count == start && n < budget) begin
            tick();
            n++;
        end
        if (pop_count == start) checkOutput("pop_timeout", pop_count, start + 1);
    endtask

    // FIFO model: consume a chunk on each sampled rd_en, then refresh in_avail/rd_data after the edge.
    initial begin
        bit pop_now;
        in_avail = 1'b0;
        rd_data  = '0;
        forever begin
            @(negedge clk_in);
            pop_now = rd_en_r;
            @(posedge clk_in);
            #2;
            if (pop_now && fifo.size() > 0) fifo.delete(0);
            in_avail = gate && (fifo.size() > 0);
            rd_data  = (fifo.size() > 0) ? fifo[0] : '0;
        end
    end

    // Monitor: protocol checks every cycle and scoreboard comparison on each accepted result.
    initial begin
        forever begin
            @(negedge clk_in);
            cycle++;
            if (rst_in) begin
                pops_vec   = 0;
                prev_valid = 1'b0;
            end else begin
                if (rd_en_r) begin
                    pop_count++;
                    pops_vec++;
                    last_pop = cycle;
                end
                if (!in_avail) checkOutput("rd_en_without_avail", 32'(rd_en_r | rd_en_n), 0);
                if (out_valid_r || out_valid_n) begin
                    checkOutput("valid_lanes_agree", 32'(out_valid_n), 32'(out_valid_r));
                    checkOutput("rd_en_while_valid", 32'(rd_en_r | rd_en_n), 0);
                end
                if (out_valid_r && !prev_valid) begin
                    checkOutput("valid_latency", cycle - last_pop, 3);
                    checkOutput("pops_per_vector", pops_vec, NCH);
                end
                if (out_valid_r && prev_valid) begin
                    checkOutput("hold_stable_relu", out_data_r, prev_data_r);
                    checkOutput("hold_stable_norelu", out_data_n, prev_data_n);
                end
                if (out_valid_r && out_ready) begin
                    if (exp_r.size() == 0) begin
                        checkOutput("unexpected_output", 1, 0);
                    end else begin
                        checkOutput("result_relu", out_data_r, exp_r.pop_front());
                        checkOutput("result_norelu", out_data_n, exp_n.pop_front());
                    end
                    pops_vec = 0;
                end
                prev_valid  = out_valid_r;
                prev_data_r = out_data_r;
                prev_data_n = out_data_n;
            end
        end
    end

    // Directed scenarios first, then a randomized run with random bubbles and back-pressure.
    initial begin
        logic [7:0] v [VE];
        int         w [VE];

        rst_in     = 1'b1;
        gate       = 1'b0;
        out_ready  = 1'b1;
        wt_wr_en   = 1'b0;
        wt_addr    = '0;
        wt_data    = '0;
        bias_wr_en = 1'b0;
        bias_data  = '0;
        mb         = 0;
        for (int i = 0; i < VE; i++) mw[i] = 0;

        tick();
        tick();
        checkOutput("reset_out_valid", 32'(out_valid_r | out_valid_n), 0);
        checkOutput("reset_out_data", out_data_r | out_data_n, 0);
        checkOutput("reset_rd_en", 32'(rd_en_r | rd_en_n), 0);
        rst_in = 1'b0;
        tick();

        $display("[TB] weights all 1, chunks 1..8");
        for (int i = 0; i < VE; i++) w[i] = 1;
        write_weights(w);
        write_bias(0);
        for (int i = 0; i < VE; i++) v[i] = 8'(i + 1);
        gate = 1'b1;
        applyStimulus(v);
        wait_drain(50);

        $display("[TB] weights -1, bias 10, input all 2");
        for (int i = 0; i < VE; i++) w[i] = -1;
        write_weights(w);
        write_bias(10);
        for (int i = 0; i < VE; i++) v[i] = 8'd2;
        applyStimulus(v);
        wait_drain(50);

        $display("[TB] in_avail bubble mid-vector, weights 0..7");
        for (int i = 0; i < VE; i++) w[i] = i;
        write_weights(w);
        write_bias(0);
        for (int i = 0; i < VE; i++) v[i] = 8'd1;
        applyStimulus(v);
        wait_pop(20);
        gate = 1'b0;
        tick();
        tick();
        gate = 1'b1;
        wait_drain(50);

        $display("[TB] out_ready held low with the next vector waiting");
        out_ready = 1'b0;
        for (int i = 0; i < VE; i++) v[i] = 8'(3 * i - 5);
        applyStimulus(v);
        for (int i = 0; i < VE; i++) v[i] = 8'(7 - 2 * i);
        applyStimulus(v);
        wait_valid(50);
        repeat (5) tick();
        out_ready = 1'b1;
        tick();
        @(negedge clk_in);
        checkOutput("first_pop_after_handshake", 32'(rd_en_r), 1);
        wait_drain(50);

        $display("[TB] -128 extremes with bias 0x7FFFFFFF");
        for (int i = 0; i < VE; i++) w[i] = -128;
        write_weights(w);
        write_bias(32'h7FFF_FFFF);
        for (int i = 0; i < VE; i++) v[i] = 8'h80;
        applyStimulus(v);
        wait_drain(50);

        $display("[TB] reset after chunk 0 abandons the vector");
        for (int i = 0; i < VE; i++) w[i] = i + 3;
        write_weights(w);
        write_bias(5);
        for (int i = 0; i < VE; i++) v[i] = 8'(i + 9);
        applyStimulus(v);
        wait_pop(20);
        gate = 1'b0;
        fifo.delete();
        void'(exp_r.pop_back());
        void'(exp_n.pop_back());
        #2;
        rst_in = 1'b1;
        #1;
        checkOutput("abort_rd_en", 32'(rd_en_r | rd_en_n), 0);
        checkOutput("abort_out_valid", 32'(out_valid_r | out_valid_n), 0);
        checkOutput("abort_out_data", out_data_r | out_data_n, 0);
        tick();
        rst_in = 1'b0;
        mb = 0;
        for (int i = 0; i < VE; i++) mw[i] = 0;
        write_bias(77);
        gate = 1'b1;
        for (int i = 0; i < VE; i++) v[i] = 8'(40 - i);
        applyStimulus(v);
        wait_drain(50);

        $display("[TB] asynchronous reset while a result is held");
        write_bias(1000);
        out_ready = 1'b0;
        applyStimulus(v);
        wait_valid(50);
        void'(exp_r.pop_back());
        void'(exp_n.pop_back());
        #2;
        rst_in = 1'b1;
        #1;
        checkOutput("async_reset_out_valid", 32'(out_valid_r | out_valid_n), 0);
        checkOutput("async_reset_out_data", out_data_r | out_data_n, 0);
        tick();
        rst_in    = 1'b0;
        out_ready = 1'b1;
        mb = 0;
        for (int i = 0; i < VE; i++) mw[i] = 0;
        tick();

        $display("[TB] randomized vectors");
        for (int t = 0; t < 20; t++) begin
            for (int i = 0; i < VE; i++) w[i] = int'($urandom_range(0, 255)) - 128;
            write_weights(w);
            write_bias(int'($urandom));
            for (int i = 0; i < VE; i++) v[i] = 8'($urandom_range(0, 255));
            applyStimulus(v);
            for (int n = 0; n < 400 && exp_r.size() > 0; n++) begin
                gate      = ($urandom_range(0, 3) != 0);
                out_ready = 1'($urandom_range(0, 1));
                tick();
            end
            gate      = 1'b1;
            out_ready = 1'b1;
            wait_drain(50);
        end

        repeat (3) tick();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
